// File: rtl/io_txsdu_pkg.sv
// io_txsdu_pkg: shared word layout, FSM states and helpers for the IO TX SDU arbiter
package io_txsdu_pkg;
  localparam int WORD_W  = 18;
  localparam int SOF_BIT = 17;
  localparam int EOF_BIT = 16;
  localparam int LEN_MSB = 10;
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef enum logic [2:0] {IDLE, HEAD, HWAIT, BODY, ABORT} state_e;
  function automatic len_t frame_len(input word_t w);
    return w[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/io_txsdu_arb_if.sv
// io_txsdu_arb_if: channel FIFO read side, TX buffer side and error flags of the arbiter
interface io_txsdu_arb_if;
  import io_txsdu_pkg::*;
  logic [1:0] chn_empty;
  logic [1:0] chn_dval;
  word_t      chn_data0;
  word_t      chn_data1;
  logic [1:0] chn_rdreq;
  logic       txbuf_afull;
  logic       arb_dval;
  word_t      arb_data;
  logic       arb_chn;
  logic       arb_abort;
  logic [1:0] frame_err;
  modport master (
    input  chn_empty, chn_dval, chn_data0, chn_data1, txbuf_afull,
    output chn_rdreq, arb_dval, arb_data, arb_chn, arb_abort, frame_err
  );
  modport slave (
    output chn_empty, chn_dval, chn_data0, chn_data1, txbuf_afull,
    input  chn_rdreq, arb_dval, arb_data, arb_chn, arb_abort, frame_err
  );
endinterface

// File: rtl/txsdu_rr_pick.sv
// txsdu_rr_pick: 2-way round-robin selector; TXSDU_ARB_PRIO_EN switches to strict channel-0 priority
module txsdu_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       vld
);
`ifdef TXSDU_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
  assign gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
`endif
  assign vld = |req;
endmodule

// File: rtl/io_txsdu_arb.sv
// io_txsdu_arb: frame-granular arbiter forwarding one whole frame per grant from two FIFOs to the TX buffer
module io_txsdu_arb
  import io_txsdu_pkg::*;
#(
  parameter int MAX_LEN = 512,
  parameter int TMO_CYC = 1023
) (
  input  logic             clk_12_5m,
  input  logic             rst_12_5m,
  io_txsdu_arb_if.master   bus
);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam len_t MAX_L = LEN_W'(MAX_LEN);
  localparam logic [TW-1:0] TMO_L = TW'(TMO_CYC - 1);
  state_e state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  len_t rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0] err_q, err_d;
  logic dval_q, dval_d, chn_q, chn_d;
  word_t data_q, data_d;
  logic [1:0] pick_req, pick_gnt;
  logic pick_vld;
  word_t word;
  len_t len;
  logic dv, hdr_ok, hdr_load, body_dv, rd_go, starve, tmo_hit, last_wd;

  assign pick_req = ~bus.chn_empty & {2{~bus.txbuf_afull}};

  txsdu_rr_pick u_pick (
    .req  (pick_req),
    .last (last_q),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  assign word     = grant_q ? bus.chn_data1 : bus.chn_data0;
  assign len      = frame_len(word);
  assign dv       = bus.chn_dval[grant_q];
  assign hdr_ok   = word[SOF_BIT] && len >= LEN_W'(2) && len <= MAX_L;
  assign hdr_load = state_q == HWAIT && dv && hdr_ok;
  assign body_dv  = state_q == BODY && dv;
  assign starve   = state_q == BODY && rd_left_q != '0 && bus.chn_empty[grant_q];
  assign rd_go    = state_q == BODY && rd_left_q != '0 && !bus.chn_empty[grant_q] && !bus.txbuf_afull;
  assign tmo_hit  = starve && tmo_q == TMO_L;
  assign last_wd  = body_dv && wr_left_q == LEN_W'(1);

  // state and datapath registers; reset drops any frame in progress without an abort pulse
  always_ff @(posedge clk_12_5m) begin
    if (rst_12_5m) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      rd_left_q <= '0;
      wr_left_q <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      dval_q    <= 1'b0;
      chn_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      dval_q    <= dval_d;
      chn_q     <= chn_d;
      data_q    <= data_d;
    end
  end

  // next state: header fetch, body streaming until the counted last word, or abort on starvation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_vld ? HWAIT : IDLE;
      HWAIT:   state_d = dv ? (hdr_ok ? BODY : IDLE) : HWAIT;
      BODY:    state_d = last_wd ? IDLE : tmo_hit ? ABORT : BODY;
      default: state_d = IDLE;
    endcase
  end

  // counters, error flags, registered output word and the combinational read request
  always_comb begin
    grant_d       = (state_q == IDLE && pick_vld) ? pick_gnt[1] : grant_q;
    last_d        = last_wd ? grant_q : last_q;
    rd_left_d     = hdr_load ? len - LEN_W'(1) : rd_left_q - LEN_W'(rd_go);
    wr_left_d     = hdr_load ? len - LEN_W'(1) : wr_left_q - LEN_W'(body_dv);
    tmo_d         = (state_q != BODY || rd_go) ? '0 : tmo_q + TW'(starve);
    err_d         = err_q | {tmo_hit, (state_q == HWAIT && dv && !hdr_ok) ||
                    (body_dv && (word[SOF_BIT] || (wr_left_q == LEN_W'(1) && !word[EOF_BIT])))};
    dval_d        = hdr_load || body_dv;
    data_d        = dval_d ? word : data_q;
    chn_d         = dval_d ? grant_q : chn_q;
    bus.chn_rdreq = rst_12_5m ? 2'b00 : state_q == IDLE ? pick_gnt : {rd_go && grant_q, rd_go && !grant_q};
    bus.arb_abort = state_q == ABORT;
    bus.arb_dval  = dval_q;
    bus.arb_data  = data_q;
    bus.arb_chn   = chn_q;
    bus.frame_err = err_q;
  end
endmodule
